// File: rtl/hwpe_tcdm_slave_mem_pkg.sv
// Shared types and address-decode helper for the TCDM slave memory model.
package hwpe_tcdm_mem_package;

  localparam int unsigned DEF_N_BANKS    = 4;
  localparam int unsigned DEF_BANK_DEPTH = 1024;
  localparam int unsigned BANK_SEL_W     = $clog2(DEF_N_BANKS);
  localparam int unsigned ROW_W          = $clog2(DEF_BANK_DEPTH);

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic        r_valid;
    logic [31:0] r_data;
  } tcdm_resp_t;

  // Word-interleaved bank index; returned zero-extended so callers compare without truncation.
  function automatic logic [31:0] bank_decode(input logic [31:0] add, input int unsigned sel_w);
    return (add >> 2) & ((32'd1 << sel_w) - 32'd1);
  endfunction

endpackage

// File: rtl/hwpe_tcdm_slave_mem_rr_arbiter.sv
// Round-robin arbiter for one memory bank: one-hot grant, pointer advances past each winner.
module hwpe_tcdm_rr_arbiter #(
  parameter int unsigned NR = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [NR-1:0] req_i,
  output logic [NR-1:0] gnt_o
);

  localparam int unsigned PTR_W = (NR > 1) ? $clog2(NR) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  int unsigned      idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    if (en_i) begin
      for (int i = 0; i < NR; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NR) idx = idx - NR;
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          ptr_d      = (idx == NR - 1) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hwpe_tcdm_slave_mem.sv
// Multi-port word-interleaved TCDM responder with per-bank round-robin arbitration.
// Optional random grant stalls via macro HWPE_TCDM_STALL_EN.
module hwpe_tcdm_slave_mem
  import hwpe_tcdm_mem_package::*;
#(
  parameter int unsigned MP         = 3,
  parameter int unsigned N_BANKS    = 1 << BANK_SEL_W,
  parameter int unsigned BANK_DEPTH = 1 << ROW_W,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid
);

  localparam int unsigned BS_W = $clog2(N_BANKS);
  localparam int unsigned RW   = $clog2(BANK_DEPTH);

  logic [MP-1:0] bank_req [N_BANKS];
  logic [MP-1:0] bank_gnt [N_BANKS];
  logic [31:0]   bank_rdata [N_BANKS];
  logic          grant_en;

`ifdef HWPE_TCDM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign grant_en = (lfsr_q[1:0] != 2'b11);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= STALL_SEED;
    else         lfsr_q <= lfsr_d;
  end
`else
  logic unused_seed;
  assign grant_en    = 1'b1;
  assign unused_seed = ^STALL_SEED;
`endif

  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
    tcdm_req_t   sel;
    logic [RW-1:0] row;
    logic [31:0] mem [BANK_DEPTH];
    logic [31:0] rdata_q;
    logic        unused_addr;

    for (genvar gj = 0; gj < MP; gj++) begin : g_req
      assign bank_req[gi][gj] = tcdm_req[gj] && (bank_decode(tcdm_add[gj], BS_W) == 32'(gi));
    end

    hwpe_tcdm_rr_arbiter #(.NR(MP)) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (grant_en),
      .req_i  (bank_req[gi]),
      .gnt_o  (bank_gnt[gi])
    );

    always_comb begin
      sel = '0;
      for (int p = 0; p < MP; p++) begin
        if (bank_gnt[gi][p]) begin
          sel = '{req: 1'b1, add: tcdm_add[p], wen: tcdm_wen[p], be: tcdm_be[p], data: tcdm_data[p]};
        end
      end
    end

    // Byte offset and bits above the row deliberately alias.
    assign row         = sel.add[2+BS_W +: RW];
    assign unused_addr = ^{sel.add[1:0], sel.add[31:2+BS_W+RW]};

    always_ff @(posedge clk_i) begin
      if (sel.req) begin
        if (sel.wen) begin
          rdata_q <= mem[row];
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (sel.be[i]) mem[row][8*i +: 8] <= sel.data[8*i +: 8];
          end
        end
      end
    end

    assign bank_rdata[gi] = rdata_q;
  end

  always_comb begin
    tcdm_gnt = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int p = 0; p < MP; p++) tcdm_gnt[p] = tcdm_gnt[p] | bank_gnt[b][p];
    end
  end

  logic [MP-1:0]           rvalid_q, rvalid_d, wen_q, wen_d;
  logic [MP-1:0][BS_W-1:0] rbank_q, rbank_d;

  always_comb begin
    rvalid_d = tcdm_gnt;
    wen_d    = wen_q;
    rbank_d  = rbank_q;
    for (int p = 0; p < MP; p++) begin
      if (tcdm_gnt[p]) wen_d[p] = tcdm_wen[p];
      for (int b = 0; b < N_BANKS; b++) begin
        if (bank_gnt[b][p]) rbank_d[p] = BS_W'(b);
      end
    end
  end

  // Async clear drops any in-flight response the instant reset asserts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      wen_q    <= '0;
      rbank_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      wen_q    <= wen_d;
      rbank_q  <= rbank_d;
    end
  end

  tcdm_resp_t [MP-1:0] resp;

  for (genvar gi = 0; gi < MP; gi++) begin : g_resp
    assign resp[gi].r_valid = rvalid_q[gi];
    assign resp[gi].r_data  = (rvalid_q[gi] && wen_q[gi]) ? bank_rdata[rbank_q[gi]] : 32'h0;
    assign tcdm_r_valid[gi] = resp[gi].r_valid;
    assign tcdm_r_data[gi]  = resp[gi].r_data;
  end

endmodule

// File: tb/tb_hwpe_tcdm_slave_mem.sv
// Directed bench for hwpe_tcdm_slave_mem: cycle-by-cycle vector table plus reset/stall sequences.
module tb_hwpe_tcdm_slave_mem;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [2:0]        tcdm_req;
  logic [2:0]        tcdm_gnt;
  logic [2:0][31:0]  tcdm_add;
  logic [2:0]        tcdm_wen;
  logic [2:0][3:0]   tcdm_be;
  logic [2:0][31:0]  tcdm_data;
  logic [2:0][31:0]  tcdm_r_data;
  logic [2:0]        tcdm_r_valid;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  hwpe_tcdm_slave_mem #(
    .MP(3), .N_BANKS(4), .BANK_DEPTH(1024), .STALL_SEED(16'hACE1)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tcdm_req     (tcdm_req),
    .tcdm_gnt     (tcdm_gnt),
    .tcdm_add     (tcdm_add),
    .tcdm_wen     (tcdm_wen),
    .tcdm_be      (tcdm_be),
    .tcdm_data    (tcdm_data),
    .tcdm_r_data  (tcdm_r_data),
    .tcdm_r_valid (tcdm_r_valid)
  );

  typedef struct {
    logic [2:0]       req;
    logic [2:0]       wen;
    logic [2:0][31:0] add;
    logic [3:0]       be;
    logic [2:0][31:0] data;
    logic [2:0]       exp_gnt;
    logic [2:0]       exp_rvalid;
    logic [2:0][31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] req, input logic [2:0] wen,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [3:0] be,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [2:0] eg, input logic [2:0] ev,
                         input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
    vec_t v;
    v.req = req; v.wen = wen; v.add = {a2, a1, a0}; v.be = be; v.data = {d2, d1, d0};
    v.exp_gnt = eg; v.exp_rvalid = ev; v.exp_rdata = {r2, r1, r0};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    tcdm_req = '0; tcdm_wen = '0; tcdm_add = '0; tcdm_be = '0; tcdm_data = '0;
  endtask

  // Independent response model: every grant yields r_valid on the following cycle.
  logic [2:0] prev_gnt;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_gnt <= '0;
    else         prev_gnt <= tcdm_gnt;
  end
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) check("resp_follows_gnt", {93'b0, tcdm_r_valid}, {93'b0, prev_gnt});
  end

  initial begin
    logic [2:0] pend;
    int cyc;
    drive_idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_rvalid", {93'b0, tcdm_r_valid}, 96'b0);
    check("reset_rdata", tcdm_r_data, 96'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

`ifndef HWPE_TCDM_STALL_EN
    //       req     wen     a0        a1        a2        be       d0            d1            d2            gnt     rvalid  r0            r1            r2
    add_vec(3'b000, 3'b000, 32'h0,    32'h0,    32'h0,    4'hF, 32'h0,        32'h0,        32'h0,        3'b000, 3'b000, 32'h0,        32'h0,        32'h0);
    add_vec(3'b001, 3'b000, 32'h10,   32'h0,    32'h0,    4'hF, 32'hDEADBEEF, 32'h0,        32'h0,        3'b001, 3'b000, 32'h0,        32'h0,        32'h0);
    add_vec(3'b010, 3'b010, 32'h0,    32'h10,   32'h0,    4'h0, 32'h0,        32'h0,        32'h0,        3'b010, 3'b001, 32'h0,        32'h0,        32'h0);
    add_vec(3'b000, 3'b000, 32'h0,    32'h0,    32'h0,    4'h0, 32'h0,        32'h0,        32'h0,        3'b000, 3'b010, 32'h0,        32'hDEADBEEF, 32'h0);
    add_vec(3'b100, 3'b000, 32'h0,    32'h0,    32'h10,   4'h5, 32'h0,        32'h0,        32'h11223344, 3'b100, 3'b000, 32'h0,        32'h0,        32'h0);
    add_vec(3'b001, 3'b001, 32'h10,   32'h0,    32'h0,    4'h0, 32'h0,        32'h0,        32'h0,        3'b001, 3'b100, 32'h0,        32'h0,        32'h0);
    add_vec(3'b000, 3'b000, 32'h0,    32'h0,    32'h0,    4'h0, 32'h0,        32'h0,        32'h0,        3'b000, 3'b001, 32'hDE22BE44, 32'h0,        32'h0);
    add_vec(3'b111, 3'b000, 32'h0,    32'h4,    32'h8,    4'hF, 32'hA0000000, 32'hA1000001, 32'hA2000002, 3'b111, 3'b000, 32'h0,        32'h0,        32'h0);
    add_vec(3'b111, 3'b111, 32'h8,    32'h0,    32'h4,    4'h0, 32'h0,        32'h0,        32'h0,        3'b111, 3'b111, 32'h0,        32'h0,        32'h0);
    add_vec(3'b000, 3'b000, 32'h0,    32'h0,    32'h0,    4'h0, 32'h0,        32'h0,        32'h0,        3'b000, 3'b111, 32'hA2000002, 32'hA0000000, 32'hA1000001);
    add_vec(3'b010, 3'b000, 32'h0,    32'h4010, 32'h0,    4'hF, 32'h0,        32'hCAFEF00D, 32'h0,        3'b010, 3'b000, 32'h0,        32'h0,        32'h0);
    add_vec(3'b100, 3'b100, 32'h0,    32'h0,    32'h10,   4'h0, 32'h0,        32'h0,        32'h0,        3'b100, 3'b010, 32'h0,        32'h0,        32'h0);
    add_vec(3'b100, 3'b000, 32'h0,    32'h0,    32'h10,   4'h0, 32'h0,        32'h0,        32'hFFFFFFFF, 3'b100, 3'b100, 32'h0,        32'h0,        32'hCAFEF00D);
    add_vec(3'b111, 3'b111, 32'h10,   32'h10,   32'h10,   4'h0, 32'h0,        32'h0,        32'h0,        3'b001, 3'b100, 32'h0,        32'h0,        32'h0);
    add_vec(3'b111, 3'b111, 32'h10,   32'h10,   32'h10,   4'h0, 32'h0,        32'h0,        32'h0,        3'b010, 3'b001, 32'hCAFEF00D, 32'h0,        32'h0);
    add_vec(3'b111, 3'b111, 32'h10,   32'h10,   32'h10,   4'h0, 32'h0,        32'h0,        32'h0,        3'b100, 3'b010, 32'h0,        32'hCAFEF00D, 32'h0);
    add_vec(3'b111, 3'b111, 32'h10,   32'h10,   32'h10,   4'h0, 32'h0,        32'h0,        32'h0,        3'b001, 3'b100, 32'h0,        32'h0,        32'hCAFEF00D);
    add_vec(3'b111, 3'b111, 32'h10,   32'h10,   32'h10,   4'h0, 32'h0,        32'h0,        32'h0,        3'b010, 3'b001, 32'hCAFEF00D, 32'h0,        32'h0);
    add_vec(3'b111, 3'b111, 32'h10,   32'h10,   32'h10,   4'h0, 32'h0,        32'h0,        32'h0,        3'b100, 3'b010, 32'h0,        32'hCAFEF00D, 32'h0);
    add_vec(3'b000, 3'b000, 32'h0,    32'h0,    32'h0,    4'h0, 32'h0,        32'h0,        32'h0,        3'b000, 3'b100, 32'h0,        32'h0,        32'hCAFEF00D);

    foreach (vecs[i]) begin
      @(negedge clk_i);
      tcdm_req = vecs[i].req; tcdm_wen = vecs[i].wen; tcdm_add = vecs[i].add;
      tcdm_be = {3{vecs[i].be}}; tcdm_data = vecs[i].data;
      #1;
      check($sformatf("vec%0d_gnt", i), {93'b0, tcdm_gnt}, {93'b0, vecs[i].exp_gnt});
      check($sformatf("vec%0d_rvalid", i), {93'b0, tcdm_r_valid}, {93'b0, vecs[i].exp_rvalid});
      check($sformatf("vec%0d_rdata", i), tcdm_r_data, vecs[i].exp_rdata);
      $display("vec %0d req=%b wen=%b gnt=%b r_valid=%b r_data=%h", i, tcdm_req, tcdm_wen,
               tcdm_gnt, tcdm_r_valid, tcdm_r_data);
    end

    // Read outstanding when reset hits: response must vanish at once and never reappear.
    @(negedge clk_i);
    drive_idle();
    tcdm_req = 3'b001; tcdm_wen = 3'b001; tcdm_add[0] = 32'h10;
    #1;
    check("pre_reset_gnt", {93'b0, tcdm_gnt}, {93'b0, 3'b001});
    @(posedge clk_i);
    #1;
    check("pre_reset_rvalid", {93'b0, tcdm_r_valid}, {93'b0, 3'b001});
    check("pre_reset_rdata", tcdm_r_data, {64'h0, 32'hCAFEF00D});
    #1;
    rst_ni = 1'b0;
    drive_idle();
    #1;
    check("reset_drop_rvalid", {93'b0, tcdm_r_valid}, 96'b0);
    check("reset_drop_rdata", tcdm_r_data, 96'b0);
    $display("reset asserted with read outstanding: r_valid=%b", tcdm_r_valid);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #1;
      check($sformatf("no_stray%0d", c), {93'b0, tcdm_r_valid}, 96'b0);
    end

    // Pointer must restart at port 0 after reset.
    @(negedge clk_i);
    tcdm_req = 3'b111; tcdm_wen = 3'b000; tcdm_be = {3{4'hF}};
    tcdm_add = {32'h30, 32'h20, 32'h10}; tcdm_data = {32'h3, 32'h2, 32'h1};
    #1;
    check("post_reset_rr0", {93'b0, tcdm_gnt}, {93'b0, 3'b001});
    $display("post-reset contention gnt=%b", tcdm_gnt);
    @(negedge clk_i);
    #1;
    check("post_reset_rr1", {93'b0, tcdm_gnt}, {93'b0, 3'b010});
    check("post_reset_wr_rvalid", {93'b0, tcdm_r_valid}, {93'b0, 3'b001});
    check("post_reset_wr_rdata", tcdm_r_data, 96'b0);
    @(negedge clk_i);
    drive_idle();
`else
    for (int t = 0; t < 8; t++) begin
      pend = 3'b111;
      cyc  = 0;
      while (pend != 3'b000 && cyc < 100) begin
        @(negedge clk_i);
        tcdm_req = pend; tcdm_wen = 3'b000; tcdm_be = {3{4'hF}};
        tcdm_add = {32'h30 + 32'(t * 64), 32'h20 + 32'(t * 64), 32'h10 + 32'(t * 64)};
        tcdm_data = {32'(t), 32'(t), 32'(t)};
        #1;
        check("stall_gnt_without_req", {93'b0, tcdm_gnt & ~pend}, 96'b0);
        pend = pend & ~tcdm_gnt;
        cyc++;
      end
      check("stall_liveness", {93'b0, pend}, 96'b0);
      $display("stall round %0d: all ports granted after %0d cycles", t, cyc);
    end
    @(negedge clk_i);
    drive_idle();
`endif

    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
